// File: rtl/sound_pkg.sv
// sound_pkg: shared types, sizes, the note ROM and the priority helper for the sound sequencer
package sound_pkg;
    localparam int NUM_EVENTS = 4;
    localparam int SEQ_LEN = 4;
    localparam int NOTE_W = 8;
    localparam int DUR_W = 4;
    localparam int EV_W = $clog2(NUM_EVENTS);
    localparam int STEP_W = $clog2(SEQ_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    typedef struct packed {
        logic [NOTE_W-1:0] code;
        logic [DUR_W-1:0]  dur;
    } note_t;

    // Indexed by {event, step}; dur == 0 marks the end of a sequence, code == 0 is a rest
    localparam note_t [0:NUM_EVENTS*SEQ_LEN-1] ROM = '{
        '{8'd50, 4'd4}, '{8'd40, 4'd4}, '{8'd30, 4'd8}, '{8'd0, 4'd0},
        '{8'd40, 4'd2}, '{8'd30, 4'd2}, '{8'd0, 4'd0},  '{8'd0, 4'd0},
        '{8'd60, 4'd1}, '{8'd0, 4'd0},  '{8'd0, 4'd0},  '{8'd0, 4'd0},
        '{8'd30, 4'd1}, '{8'd0, 4'd1},  '{8'd30, 4'd1}, '{8'd0, 4'd0}
    };

    function automatic logic [EV_W-1:0] pri_enc(input logic [NUM_EVENTS-1:0] v);
        pri_enc = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--)
            if (v[i]) pri_enc = EV_W'(i);
    endfunction
endpackage

// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: game-event requests in, amplifier and status signals out
interface sound_sequencer_if;
    import sound_pkg::*;
    logic [NUM_EVENTS-1:0] event_req;
    logic                  audio;
    logic                  gain;
    logic                  notshutdown;
    logic                  busy;
    logic [EV_W-1:0]       cur_event;
    modport master (output event_req, input audio, gain, notshutdown, busy, cur_event);
    modport slave (input event_req, output audio, gain, notshutdown, busy, cur_event);
endinterface

// File: rtl/sound_tone_gen.sv
// sound_tone_gen: square wave toggling every half_period cycles; a zero half-period is a silent rest
module sound_tone_gen #(
    parameter int HP_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            enable,
    input  logic [HP_W-1:0] half_period,
    output logic            audio
);
    logic [HP_W-1:0] hp;
    logic [HP_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hp    <= '0;
            cnt   <= '0;
            audio <= 1'b0;
        end else if (load) begin
            hp    <= half_period;
            cnt   <= '0;
            audio <= 1'b0;
        end else if (!enable || hp == '0) begin
            cnt   <= '0;
            audio <= 1'b0;
        end else if (cnt == hp - HP_W'(1)) begin
            cnt   <= '0;
            audio <= ~audio;
        end else begin
            cnt <= cnt + HP_W'(1);
        end
    end
endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: latches game events, arbitrates by priority and plays each event's ROM note sequence
module sound_sequencer import sound_pkg::*; #(
    parameter int TONE_SHIFT = 6,
    parameter bit PREEMPT    = 1'b1,
    parameter bit GAIN_HI    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic slowen,
    sound_sequencer_if.slave bus
);
    localparam int HP_W = NOTE_W + TONE_SHIFT;

    state_t                state;
    logic [NUM_EVENTS-1:0] pending;
    logic [NUM_EVENTS-1:0] pend_next;
    logic [NUM_EVENTS-1:0] sel_mask;
    logic [NUM_EVENTS-1:0] start_pend;
    logic [EV_W-1:0]       ev;
    logic [EV_W-1:0]       sel;
    logic [STEP_W-1:0]     step;
    logic [DUR_W-1:0]      dur_cnt;
    note_t                 note;
    logic                  preempt;
    logic                  tone_audio;

    assign pend_next = pending | bus.event_req;
    assign sel       = pri_enc(pend_next);
    assign sel_mask  = NUM_EVENTS'(1) << sel;
    // A fresh request for the event being started is only kept if it was already waiting
    assign start_pend = (pend_next & ~sel_mask) | (pending & bus.event_req & sel_mask);
    assign note      = ROM[{ev, step}];
    assign preempt   = PREEMPT && pend_next != '0 && sel < ev;

    assign bus.cur_event = ev;
    assign bus.audio     = tone_audio & (state == PLAY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            pending         <= '0;
            ev              <= '0;
            step            <= '0;
            dur_cnt         <= '0;
            bus.busy        <= 1'b0;
            bus.notshutdown <= 1'b0;
            bus.gain        <= 1'b0;
        end else begin
            pending <= pend_next;
            case (state)
                IDLE: if (pend_next != '0) begin
                    state           <= LOAD;
                    ev              <= sel;
                    step            <= '0;
                    pending         <= start_pend;
                    bus.busy        <= 1'b1;
                    bus.notshutdown <= 1'b1;
                    bus.gain        <= GAIN_HI;
                end
                LOAD: if (note.dur == '0) begin
                    state           <= IDLE;
                    bus.busy        <= 1'b0;
                    bus.notshutdown <= 1'b0;
                    bus.gain        <= 1'b0;
                end else begin
                    dur_cnt <= note.dur;
                    state   <= PLAY;
                end
                PLAY: if (preempt) begin
                    state   <= LOAD;
                    ev      <= sel;
                    step    <= '0;
                    pending <= start_pend;
                end else if (slowen) begin
                    if (dur_cnt != DUR_W'(1)) begin
                        dur_cnt <= dur_cnt - DUR_W'(1);
                    end else if (step == STEP_W'(SEQ_LEN - 1)) begin
                        state           <= IDLE;
                        bus.busy        <= 1'b0;
                        bus.notshutdown <= 1'b0;
                        bus.gain        <= 1'b0;
                    end else begin
                        step  <= step + STEP_W'(1);
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    sound_tone_gen #(.HP_W(HP_W)) u_tone (
        .clk         (clk),
        .rst         (rst),
        .load        (state == LOAD),
        .enable      (state == PLAY),
        .half_period (HP_W'(note.code) << TONE_SHIFT),
        .audio       (tone_audio)
    );
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: two sequencers (preempting and non-preempting) checked cycle by cycle against a note-schedule model
module tb_sound_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       slowen = 1'b0;
    logic [3:0] event_req = 4'b0;
    logic       rnd_slow = 1'b0;
    int         scnt = 0;
    int         checks = 0;
    int         errors = 0;

    int rc [4][4] = '{'{50, 40, 30, 0}, '{40, 30, 0, 0}, '{60, 0, 0, 0}, '{30, 0, 30, 0}};
    int rd [4][4] = '{'{4, 4, 8, 0}, '{2, 2, 0, 0}, '{1, 0, 0, 0}, '{1, 1, 1, 0}};

    always #5 clk = ~clk;

    sound_sequencer_if bus0 ();
    sound_sequencer_if bus1 ();
    assign bus0.event_req = event_req;
    assign bus1.event_req = event_req;

    sound_sequencer #(.TONE_SHIFT(0), .PREEMPT(1'b1), .GAIN_HI(1'b0)) u0 (
        .clk(clk), .rst(rst), .slowen(slowen), .bus(bus0));
    sound_sequencer #(.TONE_SHIFT(1), .PREEMPT(1'b0), .GAIN_HI(1'b1)) u1 (
        .clk(clk), .rst(rst), .slowen(slowen), .bus(bus1));

    logic [1:0] busy_o, ns_o, gain_o, audio_o;
    logic [1:0] cev_o [2];
    assign busy_o  = {bus1.busy, bus0.busy};
    assign ns_o    = {bus1.notshutdown, bus0.notshutdown};
    assign gain_o  = {bus1.gain, bus0.gain};
    assign audio_o = {bus1.audio, bus0.audio};
    assign cev_o[0] = bus0.cur_event;
    assign cev_o[1] = bus1.cur_event;

    task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t busy/ns/gain/audio/ev got %b expected %b", nm, $time, act, exp);
            if (errors >= 40) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        localparam bit PE = (g == 0);
        localparam bit GH = (g == 1);
        localparam int TS = g;
        int ph = 0, pend = 0, ev = 0, step = 0, ticks = 0, pc = 0, hp = 0;
        logic [5:0] q[$];

        task automatic start_ev(input int i, input int pn, input int er);
            pend = (pn & ~(1 << i)) | (pend & er & (1 << i));
            ev = i;
            step = 0;
            ph = 1;
        endtask

        // ph: 0 quiet, 1 fetching a note, 2 sounding; pc counts cycles spent sounding the note
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                ph = 0; pend = 0; ev = 0; step = 0; ticks = 0; pc = 0; hp = 0;
                q.delete();
            end else begin
                int er, pn, lo;
                logic aud;
                er = int'(event_req);
                pn = pend | er;
                lo = -1;
                for (int i = 3; i >= 0; i--) if (pn[i]) lo = i;
                if (ph == 0) begin
                    if (lo >= 0) start_ev(lo, pn, er);
                    else pend = pn;
                end else if (ph == 1) begin
                    pend = pn;
                    if (rd[ev][step] == 0) ph = 0;
                    else begin
                        hp = rc[ev][step] << TS;
                        ticks = rd[ev][step];
                        pc = 0;
                        ph = 2;
                    end
                end else if (PE && lo >= 0 && lo < ev) begin
                    start_ev(lo, pn, er);
                end else begin
                    pend = pn;
                    pc++;
                    if (slowen) begin
                        ticks--;
                        if (ticks == 0) begin
                            if (step == 3) ph = 0;
                            else begin step++; ph = 1; end
                        end
                    end
                end
                aud = (ph == 2 && hp != 0) ? ((pc / hp) % 2 == 1) : 1'b0;
                q.push_back({ph != 0, ph != 0, GH && ph != 0, aud, 2'(ev)});
            end
        end

        always @(negedge clk) begin
            logic [5:0] act;
            act = {busy_o[g], ns_o[g], gain_o[g], audio_o[g], cev_o[g]};
            if (!rst) check(g ? "reset_np" : "reset_p", act, 6'b0);
            else if (q.size() > 0) check(g ? "sb_np" : "sb_p", act, q.pop_front());
        end
    end

    task automatic cyc(input logic [3:0] er);
        @(negedge clk);
        event_req = er;
        slowen = rnd_slow ? ($urandom_range(0, 59) == 0) : (scnt == 199);
        scnt = (scnt == 199) ? 0 : scnt + 1;
    endtask

    task automatic run_idle();
        int quiet = 0;
        for (int n = 0; n < 20000 && quiet < 3; n++) begin
            cyc(4'b0);
            quiet = (busy_o == 2'b00) ? quiet + 1 : 0;
        end
        checks++;
        if (quiet < 3) begin
            errors++;
            $display("FAIL idle_timeout busy got %b expected 00", busy_o);
        end
    endtask

    initial begin
        repeat (3) cyc(4'b0);
        rst = 1'b1;
        repeat (20) cyc(4'b0);
        scnt = 0; cyc(4'b0100); run_idle();
        scnt = 0; cyc(4'b0010); run_idle();
        scnt = 0; cyc(4'b1000); run_idle();
        scnt = 0; cyc(4'b1000); repeat (20) cyc(4'b0); cyc(4'b0001); run_idle();
        scnt = 0; cyc(4'b0110); run_idle();
        scnt = 0; cyc(4'b0001); repeat (100) cyc(4'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_reset_p", {busy_o[0], ns_o[0], gain_o[0], audio_o[0], 2'b00}, 6'b0);
        check("async_reset_np", {busy_o[1], ns_o[1], gain_o[1], audio_o[1], 2'b00}, 6'b0);
        repeat (3) cyc(4'b0);
        rst = 1'b1;
        repeat (20) cyc(4'b0);
        rnd_slow = 1'b1;
        repeat (15000) cyc(($urandom_range(0, 299) == 0) ? 4'($urandom_range(1, 15)) : 4'b0);
        run_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
